// File: rtl/press_decoder.sv
// press_decoder: debounces the lock push-button, times each press, classifies
// it as short (0) or long (1), packs the symbols into a code word and hands
// the word to the lock controller over a valid/ack handshake.
// Optional feature macro: PRESS_ABORT_EN (a very long press cancels the entry).
module press_decoder #(
  parameter int unsigned DEBOUNCE_CYC = 120000,
  parameter int unsigned LONG_CYC     = 6000000,
  parameter int unsigned GAP_CYC      = 24000000,
  parameter int unsigned ABORT_CYC    = 36000000,
  parameter int unsigned MAX_SYM      = 8,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               hwclk,
  input  logic               rst,
  input  logic               button,
  input  logic               enable,
  output logic               symbol_strobe,
  output logic               symbol_long,
  output logic               code_valid,
  output logic [MAX_SYM-1:0] code,
  output logic [3:0]         code_len,
  input  logic               code_ack,
  output logic               abort
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_REPORT,
    S_ABORT_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               btn_meta_q, btn_meta_d;
  logic               btn_sync_q, btn_sync_d;
  logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic               db_level_q, db_level_d;
  logic               db_rise_q, db_rise_d;
  logic               db_fall_q, db_fall_d;
  logic [CNT_W-1:0]   press_timer_q, press_timer_d;
  logic [CNT_W-1:0]   gap_timer_q, gap_timer_d;
  logic               strobe_q, strobe_d;
  logic               long_q, long_d;
  logic               valid_q, valid_d;
  logic [MAX_SYM-1:0] code_q, code_d;
  logic [3:0]         len_q, len_d;
  logic               is_long;
  logic [CNT_W-1:0]   db_cnt_inc;
  logic [CNT_W-1:0]   gap_inc;
`ifdef PRESS_ABORT_EN
  logic               abort_q, abort_d;
`endif

  // Two-flop synchronizer for the asynchronous button pin.
  always_comb begin
    btn_meta_d = button;
    btn_sync_d = btn_meta_q;
  end

  // Debounce: accept a new level after DEBOUNCE_CYC consecutive samples of it;
  // the one-cycle rise/fall flags line up with the new debounced level.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    db_rise_d  = 1'b0;
    db_fall_d  = 1'b0;
    db_cnt_inc = db_cnt_q + CNT_W'(1);
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_inc >= CNT_W'(DEBOUNCE_CYC)) begin
        db_level_d = btn_sync_q;
        db_cnt_d   = '0;
        db_rise_d  = btn_sync_q;
        db_fall_d  = ~btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_inc;
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Press timer: counts every cycle the debounced level is high, saturating,
  // so when the fall flag is seen it holds the debounced press length.
  always_comb begin
    press_timer_d = '0;
    if (db_level_q) begin
      press_timer_d = (press_timer_q == '1) ? press_timer_q : press_timer_q + CNT_W'(1);
    end
  end

  assign is_long = (press_timer_q >= CNT_W'(LONG_CYC));
  assign gap_inc = gap_timer_q + CNT_W'(1);

  // Entry FSM: next state, symbol packing and handshake outputs.
  always_comb begin
    state_d     = state_q;
    gap_timer_d = gap_timer_q;
    strobe_d    = 1'b0;
    long_d      = long_q;
    valid_d     = valid_q;
    code_d      = code_q;
    len_d       = len_q;
`ifdef PRESS_ABORT_EN
    abort_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (db_rise_q && enable) begin
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        if (db_fall_q) begin
          strobe_d = 1'b1;
          long_d   = is_long;
          for (int unsigned k = 0; k < MAX_SYM; k++) begin
            if (len_q == 4'(k)) begin
              code_d[k] = is_long;
            end
          end
          len_d = len_q + 4'd1;
          if ((len_q + 4'd1) >= 4'(MAX_SYM)) begin
            state_d = S_REPORT;
            valid_d = 1'b1;
          end else begin
            state_d     = S_GAP;
            gap_timer_d = '0;
          end
        end
`ifdef PRESS_ABORT_EN
        else if (press_timer_q >= CNT_W'(ABORT_CYC)) begin
          abort_d = 1'b1;
          code_d  = '0;
          len_d   = '0;
          state_d = S_ABORT_WAIT;
        end
`endif
      end
      S_GAP: begin
        // A press arriving on the expiry cycle takes priority.
        if (db_rise_q && enable) begin
          state_d     = S_PRESS;
          gap_timer_d = '0;
        end else if (gap_inc >= CNT_W'(GAP_CYC)) begin
          state_d     = S_REPORT;
          valid_d     = 1'b1;
          gap_timer_d = gap_inc;
        end else begin
          gap_timer_d = gap_inc;
        end
      end
      S_REPORT: begin
        // Only edges start a press, so a button held through the ack needs
        // a release and a fresh press before the next entry begins.
        if (code_ack) begin
          valid_d = 1'b0;
          code_d  = '0;
          len_d   = '0;
          state_d = S_IDLE;
        end
      end
`ifdef PRESS_ABORT_EN
      S_ABORT_WAIT: begin
        if (!db_level_q) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state registers with synchronous active-high reset.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      db_cnt_q      <= '0;
      db_level_q    <= 1'b0;
      db_rise_q     <= 1'b0;
      db_fall_q     <= 1'b0;
      press_timer_q <= '0;
      gap_timer_q   <= '0;
      strobe_q      <= 1'b0;
      long_q        <= 1'b0;
      valid_q       <= 1'b0;
      code_q        <= '0;
      len_q         <= '0;
`ifdef PRESS_ABORT_EN
      abort_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      btn_meta_q    <= btn_meta_d;
      btn_sync_q    <= btn_sync_d;
      db_cnt_q      <= db_cnt_d;
      db_level_q    <= db_level_d;
      db_rise_q     <= db_rise_d;
      db_fall_q     <= db_fall_d;
      press_timer_q <= press_timer_d;
      gap_timer_q   <= gap_timer_d;
      strobe_q      <= strobe_d;
      long_q        <= long_d;
      valid_q       <= valid_d;
      code_q        <= code_d;
      len_q         <= len_d;
`ifdef PRESS_ABORT_EN
      abort_q       <= abort_d;
`endif
    end
  end

  assign symbol_strobe = strobe_q;
  assign symbol_long   = long_q;
  assign code_valid    = valid_q;
  assign code          = code_q;
  assign code_len      = len_q;
`ifdef PRESS_ABORT_EN
  assign abort         = abort_q;
`else
  assign abort         = 1'b0;
`endif

endmodule
